// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART transmitter.
// Holds the FSM state encoding, default frame geometry and counter sizing.
package uart_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } uart_state_e;

    localparam int unsigned DEF_CLOCKS_PER_PULSE = 32'd4;
    localparam int unsigned DEF_BITS_PER_WORD    = 32'd8;
    localparam int unsigned DEF_W_OUT            = 32'd16;

    // Width needed to hold 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val < 32'd1) begin
            return 32'd1;
        end else begin
            return $clog2(max_val + 32'd1);
        end
    endfunction

endpackage

// File: rtl/uart_tx.sv
// Multi-word UART transmitter: captures a payload on a valid/ready handshake
// and serialises it word 0 first, one start bit, LSB-first data, then stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE,
    parameter int unsigned BITS_PER_WORD    = DEF_BITS_PER_WORD,
    parameter int unsigned PACKET_SIZE      = DEF_BITS_PER_WORD + 32'd5,
    parameter int unsigned W_OUT            = DEF_W_OUT
) (
    input  logic                                          clk,
    input  logic                                          rstn,
    input  logic                                          s_valid,
    output logic                                          s_ready,
    input  logic [W_OUT/BITS_PER_WORD-1:0][BITS_PER_WORD-1:0] s_data,
    output logic                                          tx
);

    localparam int unsigned NUM_WORDS = W_OUT / BITS_PER_WORD;
    localparam int unsigned BAUD_W    = cnt_width(CLOCKS_PER_PULSE - 32'd1);
    localparam int unsigned BIT_W     = cnt_width(PACKET_SIZE - 32'd1);
    localparam int unsigned WORD_W    = cnt_width(NUM_WORDS - 32'd1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_PULSE - 32'd1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PACKET_SIZE - 32'd1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(NUM_WORDS - 32'd1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(32'd1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(32'd1);
    localparam logic [WORD_W-1:0] WORD_ONE  = WORD_W'(32'd1);

    if ((W_OUT % BITS_PER_WORD) != 32'd0 || W_OUT < BITS_PER_WORD) begin : g_bad_w_out
        $error("uart_tx: W_OUT must be a non-zero multiple of BITS_PER_WORD");
    end
    if (PACKET_SIZE < BITS_PER_WORD + 32'd2) begin : g_bad_packet
        $error("uart_tx: PACKET_SIZE must allow a start bit and at least one stop bit");
    end

    uart_state_e                                state_r, state_n;
    logic                                       ready_r, ready_n;
    logic [BAUD_W-1:0]                          baud_r, baud_n;
    logic [BIT_W-1:0]                           bit_r, bit_n;
    logic [WORD_W-1:0]                          word_r, word_n;
    logic [WORD_W-1:0]                          word_inc_s;
    logic [PACKET_SIZE-1:0]                     frame_r, frame_n;
    logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]    data_r, data_n;

    // Bit 0 of the frame register is the line level, so tx comes straight off a flop.
    function automatic logic [PACKET_SIZE-1:0] make_frame(input logic [BITS_PER_WORD-1:0] word);
        logic [PACKET_SIZE-1:0] f;
        f                    = {PACKET_SIZE{1'b1}};
        f[BITS_PER_WORD:1]   = word;
        f[0]                 = 1'b0;
        return f;
    endfunction

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            baud_r  <= {BAUD_W{1'b0}};
            bit_r   <= {BIT_W{1'b0}};
            word_r  <= {WORD_W{1'b0}};
            frame_r <= {PACKET_SIZE{1'b1}};
            data_r  <= {W_OUT{1'b0}};
        end else begin
            state_r <= state_n;
            ready_r <= ready_n;
            baud_r  <= baud_n;
            bit_r   <= bit_n;
            word_r  <= word_n;
            frame_r <= frame_n;
            data_r  <= data_n;
        end
    end

    // Next-state, counter and shift-register logic.
    always_comb begin
        state_n    = state_r;
        ready_n    = ready_r;
        baud_n     = baud_r;
        bit_n      = bit_r;
        word_n     = word_r;
        frame_n    = frame_r;
        data_n     = data_r;
        word_inc_s = word_r + WORD_ONE;

        case (state_r)
            IDLE: begin
                ready_n = 1'b1;
                frame_n = {PACKET_SIZE{1'b1}};
                if (s_valid && ready_r) begin
                    state_n = SEND;
                    ready_n = 1'b0;
                    data_n  = s_data;
                    frame_n = make_frame(s_data[0]);
                    baud_n  = {BAUD_W{1'b0}};
                    bit_n   = {BIT_W{1'b0}};
                    word_n  = {WORD_W{1'b0}};
                end else begin
                    state_n = IDLE;
                end
            end
            SEND: begin
                ready_n = 1'b0;
                if (baud_r == BAUD_LAST) begin
                    baud_n = {BAUD_W{1'b0}};
                    if (bit_r == BIT_LAST) begin
                        bit_n = {BIT_W{1'b0}};
                        // Last stop bit of the last word returns the line to idle.
                        if (word_r == WORD_LAST) begin
                            word_n  = {WORD_W{1'b0}};
                            state_n = IDLE;
                            ready_n = 1'b1;
                            frame_n = {PACKET_SIZE{1'b1}};
                        end else begin
                            word_n  = word_inc_s;
                            frame_n = make_frame(data_r[word_inc_s]);
                        end
                    end else begin
                        bit_n   = bit_r + BIT_ONE;
                        frame_n = {1'b1, frame_r[PACKET_SIZE-1:1]};
                    end
                end else begin
                    baud_n = baud_r + BAUD_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                ready_n = 1'b1;
                frame_n = {PACKET_SIZE{1'b1}};
            end
        endcase
    end

    assign s_ready = ready_r;
    assign tx      = frame_r[0];

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx with default parameters.
// Expected line streams are written out by hand, one character per serial bit.
module tb_uart_tx;

    logic            clk = 1'b0;
    logic            rstn;
    logic            s_valid;
    logic            s_ready;
    logic [1:0][7:0] s_data;
    logic            tx;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    uart_tx dut (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .tx      (tx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshake one payload, then check all 104 SEND cycles bit by bit.
    // mode 0: valid dropped; mode 1: stray valid pulses; mode 2: valid held with next_data.
    task automatic xfer(input logic [15:0] payload, input logic [0:25] exp, input int mode,
                        input logic [15:0] next_data, input string tag);
        s_valid = 1'b1;
        s_data  = payload;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 104; k++) begin
            chk({tag, " tx"}, {31'd0, tx}, {31'd0, exp[k/4]});
            chk({tag, " s_ready"}, {31'd0, s_ready}, 32'd0);
            case (mode)
                0: begin s_valid = 1'b0; s_data = 16'($urandom()); end
                1: begin s_valid = ((k % 7) == 3); s_data = 16'($urandom()); end
                default: begin s_valid = 1'b1; s_data = next_data; end
            endcase
            @(negedge clk);
        end
        chk({tag, " end s_ready"}, {31'd0, s_ready}, 32'd1);
        chk({tag, " end tx"}, {31'd0, tx}, 32'd1);
    endtask

    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, " tx"}, {31'd0, tx}, 32'd1);
            chk({tag, " s_ready"}, {31'd0, s_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [0:25] exp_mid;

        rstn    = 1'b1;
        s_valid = 1'b0;
        s_data  = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset tx", {31'd0, tx}, 32'd1);
        chk("reset s_ready", {31'd0, s_ready}, 32'd1);
        rstn = 1'b0;
        idle_check(50, "idle");

        xfer(16'h007F, 26'b0111111101111_0000000001111, 0, 16'h0000, "d127");
        xfer(16'hA55A, 26'b0010110101111_0101001011111, 0, 16'h0000, "a55a");

        // Second payload is already presented when s_ready rises.
        xfer(16'h00FF, 26'b0111111111111_0000000001111, 2, 16'hFF00, "b2b0");
        xfer(16'hFF00, 26'b0000000001111_0111111111111, 0, 16'h0000, "b2b1");

        xfer(16'h3C96, 26'b0011010011111_0001111001111, 1, 16'h0000, "noise");
        s_valid = 1'b0;
        idle_check(10, "noise idle");

        // Abort midway through frame 1 (bit 6 of word 1 is a 0 on the line).
        exp_mid = 26'b0001011001111_0010010001111;
        s_valid = 1'b1;
        s_data  = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 78; k++) begin
            chk("mid tx", {31'd0, tx}, {31'd0, exp_mid[k/4]});
            s_valid = 1'b0;
            @(negedge clk);
        end
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        chk("abort tx", {31'd0, tx}, 32'd1);
        chk("abort s_ready", {31'd0, s_ready}, 32'd1);
        idle_check(8, "abort idle");
        xfer(16'h0001, 26'b0100000001111_0000000001111, 0, 16'h0000, "post_rst");

        // Handshake coincident with reset must be dropped.
        s_valid = 1'b0;
        @(negedge clk);
        rstn    = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'hFFFF;
        @(negedge clk);
        rstn    = 1'b0;
        s_valid = 1'b0;
        chk("rst hs tx", {31'd0, tx}, 32'd1);
        chk("rst hs s_ready", {31'd0, s_ready}, 32'd1);
        idle_check(8, "rst hs idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLOCKS_PER_PULSE, default 4, is the number of clk cycles each serial bit is held on tx.
REQ-002 Parameter BITS_PER_WORD, default 8, is the number of data bits per UART frame.
REQ-003 Parameter PACKET_SIZE, default BITS_PER_WORD+5 (13), is the total bits per frame: 1 start bit, BITS_PER_WORD data bits, and PACKET_SIZE-BITS_PER_WORD-1 stop bits (4 by default).
REQ-004 Parameter W_OUT, default 16, is the input payload width; localparam NUM_WORDS = W_OUT/BITS_PER_WORD (2 by default).
REQ-005 The module SHALL have one clock, and reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rstn  input  1  synchronous active-high reset (name kept per codebase; asserted = 1).
REQ-008 s_valid  input  1  upstream payload valid.
REQ-009 s_ready  output  1  block idle and able to accept a payload.
REQ-010 s_data  input  [NUM_WORDS-1:0][BITS_PER_WORD-1:0]  payload; word 0 is the least significant BITS_PER_WORD bits.
REQ-011 tx  output  1  serial line; idle level 1.

Function
REQ-012 The FSM SHALL have two states: IDLE (s_ready=1, tx=1) and SEND (s_ready=0).
REQ-013 On a rising edge with s_valid=1 and s_ready=1, the block SHALL capture s_data in full and move to SEND; s_data is ignored at all other times.
REQ-014 s_valid while s_ready=0 SHALL be ignored; no payload is queued.
REQ-015 tx SHALL be registered; the start bit (0) SHALL appear on tx in the cycle after the capture edge.
REQ-016 Words SHALL be sent in order word 0 .. word NUM_WORDS-1, each as a complete frame: start 0, data LSB first, then stop bits of 1.
REQ-017 Every bit SHALL be held on tx for exactly CLOCKS_PER_PULSE cycles, with no gaps between frames.
REQ-018 SEND SHALL last exactly NUM_WORDS*PACKET_SIZE*CLOCKS_PER_PULSE cycles (104 by default); s_ready SHALL return to 1 in the next cycle.
REQ-019 A new handshake SHALL be accepted in the first cycle s_ready=1, giving back-to-back transfers with tx continuously driven.
REQ-020 Counters SHALL be sized with $clog2 of their maximum value plus 1 and SHALL wrap to 0 at each bit, frame and payload boundary.
REQ-021 Elaboration SHALL fail if W_OUT is not a multiple of BITS_PER_WORD, or if PACKET_SIZE < BITS_PER_WORD+2.

Reset
REQ-022 While rstn=1 at a clock edge, the FSM SHALL go to IDLE, all counters and the shift register SHALL clear, and tx=1 and s_ready=1 from the next cycle.
REQ-023 Reset during SEND SHALL abort the transfer immediately, with no partial frame completed.
REQ-024 A handshake in the same cycle as reset SHALL be discarded.

Structure
REQ-025 Package uart_pkg SHALL hold the FSM state enum (IDLE, SEND) and the derived-width helper localparams.
REQ-026 The block SHALL be a single module with no sub-module; the baud counter, bit counter, word counter and frame shift register are inline.

Verification
REQ-027 Reset then release: tx=1, s_ready=1, and tx stays 1 with s_valid=0 for 50 cycles.
REQ-028 s_data=127, one-cycle s_valid, defaults:
- tx shows 0,1,1,1,1,1,1,1,0,1,1,1,1 then 0,0,0,0,0,0,0,0,0,1,1,1,1;
- each bit lasts 4 cycles;
- s_ready=0 for exactly 104 cycles.
REQ-029 s_data=16'hA55A: frame 0 data bits 0,1,0,1,1,0,1,0; frame 1 data bits 1,0,1,0,0,1,0,1.
REQ-030 Back-to-back: s_valid held high with 16'h00FF then 16'hFF00; the second payload is captured in the first s_ready=1 cycle, with no idle gap beyond the stop bits.
REQ-031 s_valid pulses during SEND: no capture, and the output stream is unchanged.
REQ-032 rstn=1 for one cycle midway through frame 1: tx=1 and s_ready=1 next cycle, then a new payload 16'h0001 transmits correctly.
